// File: rtl/hpdmc_wrsched_pkg.sv
// Shared HPDMC write-sequencer definitions: FSM state encodings, parameter
// defaults and counter sizing helper used by the write scheduler.
package hpdmc_wrsched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PRE   = 3'd2,
    ST_BURST = 3'd3,
    ST_POST  = 3'd4
  } wr_state_t;

  localparam int WL_DEFAULT           = 2;
  localparam int BURST_CYCLES_DEFAULT = 4;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdmc_wrsched_if.sv
// Write command and write-FIFO handshake between the management FSM / FIFO
// (master) and the write sequencer (slave).
interface hpdmc_wrsched_if;
  logic        write;
  logic        ready;
  logic        wdata_valid;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wdata_ack;

  modport master (output write, wdata_valid, wdata, wmask,
                  input  ready, wdata_ack);

  modport slave  (input  write, wdata_valid, wdata, wmask,
                  output ready, wdata_ack);
endinterface

// File: rtl/hpdmc_wrsched.sv
// DDR write-burst sequencer: times preamble, data beats and postamble for the
// DQ/DM/DQS ODDR instances and pops one write-FIFO beat per burst clock.
module hpdmc_wrsched
  import hpdmc_wrsched_pkg::*;
#(
  parameter int WL           = WL_DEFAULT,
  parameter int BURST_CYCLES = BURST_CYCLES_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  hpdmc_wrsched_if.slave wr,
  output logic [15:0] dq_d0,
  output logic [15:0] dq_d1,
  output logic [1:0]  dm_d0,
  output logic [1:0]  dm_d1,
  output logic        dqs_d0,
  output logic        dqs_d1,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        underrun,
  input  logic        clr_underrun
);

  localparam int WW = cnt_width(WL);
  localparam int BW = cnt_width(BURST_CYCLES);
  localparam logic [WW-1:0] WAIT_LOAD = WW'((WL > 1) ? (WL - 2) : 0);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_CYCLES - 1);

  wr_state_t     state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic          chained;
  logic          accept;

  assign wr.ready = sys_rst_n & ((state == ST_IDLE) | (state == ST_POST));
  assign accept   = wr.write & wr.ready;

  // chained marks a restart taken from POST so DQS stays driven through WAIT
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
      chained  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if ((state == ST_BURST) && !wr.wdata_valid)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;

      case (state)
        ST_IDLE, ST_POST: begin
          if (accept) begin
            chained  <= (state == ST_POST);
            wait_cnt <= WAIT_LOAD;
            state    <= (WL > 1) ? ST_WAIT : ST_PRE;
          end else begin
            chained  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0)
            state <= ST_PRE;
          else
            wait_cnt <= wait_cnt - WW'(1);
        end
        ST_PRE: begin
          beat_cnt <= '0;
          chained  <= 1'b0;
          state    <= ST_BURST;
        end
        ST_BURST: begin
          if (beat_cnt == LAST_BEAT)
            state <= ST_POST;
          else
            beat_cnt <= beat_cnt + BW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data and mask follow the FIFO head combinationally during a burst beat
  always_comb begin
    wr.wdata_ack = 1'b0;
    dq_d0        = '0;
    dq_d1        = '0;
    dm_d0        = '0;
    dm_d1        = '0;
    dqs_d0       = 1'b0;
    dqs_d1       = 1'b0;
    dq_oe        = 1'b0;
    dqs_oe       = 1'b0;
    case (state)
      ST_WAIT: dqs_oe = chained;
      ST_PRE:  dqs_oe = 1'b1;
      ST_BURST: begin
        dq_oe  = 1'b1;
        dqs_oe = 1'b1;
        dqs_d0 = 1'b1;
        if (wr.wdata_valid) begin
          wr.wdata_ack = 1'b1;
          dq_d0        = wr.wdata[31:16];
          dq_d1        = wr.wdata[15:0];
          dm_d0        = ~wr.wmask[3:2];
          dm_d1        = ~wr.wmask[1:0];
        end else begin
          dm_d0 = 2'b11;
          dm_d1 = 2'b11;
        end
      end
      ST_POST: dqs_oe = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hpdmc_wrsched.sv
// Directed self-checking bench for hpdmc_wrsched with WL=2, BURST_CYCLES=4.
module tb_hpdmc_wrsched;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        clr_underrun;
  logic [15:0] dq_d0, dq_d1;
  logic [1:0]  dm_d0, dm_d1;
  logic        dqs_d0, dqs_d1, dq_oe, dqs_oe, underrun;

  int tests_run;
  int tests_failed;

  hpdmc_wrsched_if wr ();

  hpdmc_wrsched #(.WL(2), .BURST_CYCLES(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .wr           (wr),
    .dq_d0        (dq_d0),
    .dq_d1        (dq_d1),
    .dm_d0        (dm_d0),
    .dm_d1        (dm_d1),
    .dqs_d0       (dqs_d0),
    .dqs_d1       (dqs_d1),
    .dq_oe        (dq_oe),
    .dqs_oe       (dqs_oe),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  // Control word: {ready, wdata_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, dm_d0, dm_d1}
  localparam logic [9:0] C_ZERO  = 10'b0000000000;
  localparam logic [9:0] C_IDLE  = 10'b1000000000;
  localparam logic [9:0] C_WAITC = 10'b0001000000;
  localparam logic [9:0] C_PRE   = 10'b0001000000;
  localparam logic [9:0] C_BURST = 10'b0111100000;
  localparam logic [9:0] C_UNDER = 10'b0011101111;
  localparam logic [9:0] C_M6    = 10'b0111101001;
  localparam logic [9:0] C_POST  = 10'b1001000000;

  logic [9:0]  obs_ctl;
  logic [31:0] obs_dq;
  assign obs_ctl = {wr.ready, wr.wdata_ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, dm_d0, dm_d1};
  assign obs_dq  = {dq_d0, dq_d1};

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      $error("[TB] %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check mid-cycle, advance
  task automatic step(input string tag, input logic w, input logic v,
                      input logic [31:0] d, input logic [3:0] m, input logic clr,
                      input logic [9:0] exp_ctl, input logic [31:0] exp_dq,
                      input logic exp_ur);
    wr.write     = w;
    wr.wdata_valid = v;
    wr.wdata     = d;
    wr.wmask     = m;
    clr_underrun = clr;
    @(negedge sys_clk);
    check({tag, ".ctl"}, {22'd0, obs_ctl}, {22'd0, exp_ctl});
    check({tag, ".dq"},  obs_dq, exp_dq);
    check({tag, ".ur"},  {31'd0, underrun}, {31'd0, exp_ur});
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    sys_rst_n      = 1'b0;
    clr_underrun   = 1'b0;
    wr.write       = 1'b1;
    wr.wdata_valid = 1'b1;
    wr.wdata       = 32'h11112222;
    wr.wmask       = 4'hF;
    #2;
    check("reset.ctl", {22'd0, obs_ctl}, {22'd0, C_ZERO});
    check("reset.dq",  obs_dq, 32'h0);
    check("reset.ur",  {31'd0, underrun}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Basic burst; writes during cycles 1..6 must be ignored
    step("t1c0", 1, 1, 32'h11112222, 4'hF, 0, C_IDLE,  32'h0,        0);
    step("t1c1", 1, 1, 32'h11112222, 4'hF, 0, C_ZERO,  32'h0,        0);
    step("t1c2", 1, 1, 32'h11112222, 4'hF, 0, C_PRE,   32'h0,        0);
    step("t1c3", 1, 1, 32'h11112222, 4'hF, 0, C_BURST, 32'h11112222, 0);
    step("t1c4", 1, 1, 32'h33334444, 4'hF, 0, C_BURST, 32'h33334444, 0);
    step("t1c5", 1, 1, 32'h55556666, 4'hF, 0, C_BURST, 32'h55556666, 0);
    step("t1c6", 1, 1, 32'h77778888, 4'hF, 0, C_BURST, 32'h77778888, 0);
    step("t1c7", 0, 0, 32'h0,        4'hF, 0, C_POST,  32'h0,        0);
    step("t1c8", 0, 0, 32'h0,        4'hF, 0, C_IDLE,  32'h0,        0);

    // Underrun on cycle 4, then back-to-back burst accepted in POST
    step("t2c0",  1, 1, 32'h11112222, 4'hF, 0, C_IDLE,  32'h0,        0);
    step("t2c1",  0, 1, 32'h11112222, 4'hF, 0, C_ZERO,  32'h0,        0);
    step("t2c2",  0, 1, 32'h11112222, 4'hF, 0, C_PRE,   32'h0,        0);
    step("t2c3",  0, 1, 32'h11112222, 4'hF, 0, C_BURST, 32'h11112222, 0);
    step("t2c4",  0, 0, 32'hDEADBEEF, 4'hF, 0, C_UNDER, 32'h0,        0);
    step("t2c5",  0, 1, 32'h33334444, 4'hF, 0, C_BURST, 32'h33334444, 1);
    step("t2c6",  0, 1, 32'h55556666, 4'hF, 0, C_BURST, 32'h55556666, 1);
    step("t2c7",  1, 0, 32'h0,        4'hF, 0, C_POST,  32'h0,        1);
    step("t2c8",  0, 1, 32'h77778888, 4'hF, 0, C_WAITC, 32'h0,        1);
    step("t2c9",  0, 1, 32'h77778888, 4'hF, 0, C_PRE,   32'h0,        1);
    step("t2c10", 0, 1, 32'h77778888, 4'hF, 0, C_BURST, 32'h77778888, 1);
    step("t2c11", 0, 1, 32'hAAAABBBB, 4'b0110, 0, C_M6, 32'hAAAABBBB, 1);
    step("t2c12", 0, 1, 32'hCCCCDDDD, 4'hF, 0, C_BURST, 32'hCCCCDDDD, 1);
    step("t2c13", 0, 1, 32'hEEEEFFFF, 4'hF, 0, C_BURST, 32'hEEEEFFFF, 1);
    step("t2c14", 0, 0, 32'h0,        4'hF, 0, C_POST,  32'h0,        1);
    step("t2c15", 0, 0, 32'h0,        4'hF, 1, C_IDLE,  32'h0,        1);
    step("t2c16", 0, 0, 32'h0,        4'hF, 0, C_IDLE,  32'h0,        0);

    // Set beats clear, then reset asserted mid-burst
    step("t3c0", 1, 1, 32'h11112222, 4'hF, 0, C_IDLE,  32'h0, 0);
    step("t3c1", 0, 1, 32'h11112222, 4'hF, 0, C_ZERO,  32'h0, 0);
    step("t3c2", 0, 1, 32'h11112222, 4'hF, 0, C_PRE,   32'h0, 0);
    step("t3c3", 0, 0, 32'h11112222, 4'hF, 1, C_UNDER, 32'h0, 0);
    clr_underrun = 1'b0;
    wr.wdata_valid = 1'b1;
    check("t3.setwins", {31'd0, underrun}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("t3.rst.ctl", {22'd0, obs_ctl}, {22'd0, C_ZERO});
    check("t3.rst.dq",  obs_dq, 32'h0);
    check("t3.rst.ur",  {31'd0, underrun}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    step("t4c0", 1, 1, 32'h11112222, 4'hF, 0, C_IDLE,  32'h0,        0);
    step("t4c1", 0, 1, 32'h11112222, 4'hF, 0, C_ZERO,  32'h0,        0);
    step("t4c2", 0, 1, 32'h11112222, 4'hF, 0, C_PRE,   32'h0,        0);
    step("t4c3", 0, 1, 32'h11112222, 4'hF, 0, C_BURST, 32'h11112222, 0);
    step("t4c4", 0, 1, 32'h33334444, 4'hF, 0, C_BURST, 32'h33334444, 0);
    step("t4c5", 0, 1, 32'h55556666, 4'hF, 0, C_BURST, 32'h55556666, 0);
    step("t4c6", 0, 1, 32'h77778888, 4'hF, 0, C_BURST, 32'h77778888, 0);
    step("t4c7", 0, 0, 32'h0,        4'hF, 0, C_POST,  32'h0,        0);
    step("t4c8", 0, 0, 32'h0,        4'hF, 0, C_IDLE,  32'h0,        0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hpdmc_wrsched.md
HPDMC_WRSCHED -- requirements
Module: hpdmc_wrsched

Interface
REQ-001 SHALL have parameter WL, default 2, meaning write latency in sys_clk cycles from command acceptance to preamble; legal range 1..7.
REQ-002 SHALL have parameter BURST_CYCLES, default 4, meaning data clocks per burst (BL8 on x16 DDR); legal range 1..8.
REQ-003 SHALL have port sys_clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port write  in  1  write command from the management FSM; accepted when write & ready.
REQ-006 SHALL have port ready  out  1  sequencer can accept a write this cycle.
REQ-007 SHALL have port wdata_valid  in  1  write FIFO holds a beat.
REQ-008 SHALL have port wdata  in  32  beat data; [31:16] is the rising-edge half, [15:0] the falling-edge half.
REQ-009 SHALL have port wmask  in  4  byte enables, 1 = write byte; [3:2] pair with [31:16], [1:0] pair with [15:0].
REQ-010 SHALL have port wdata_ack  out  1  pops one FIFO beat this cycle.
REQ-011 SHALL have ports dq_d0 and dq_d1  out  16 each  D0/D1 to the DQ hpdmc_oddr16 instance.
REQ-012 SHALL have ports dm_d0 and dm_d1  out  2 each  DM to ODDR; 1 = byte masked.
REQ-013 SHALL have ports dqs_d0 and dqs_d1  out  1 each  DQS pattern to ODDR.
REQ-014 SHALL have ports dq_oe and dqs_oe  out  1 each  tristate enables, 1 = drive.
REQ-015 SHALL have port underrun  out  1  sticky: a burst beat found wdata_valid=0.
REQ-016 SHALL have port clr_underrun  in  1  synchronous clear of underrun.

Function
REQ-017 SHALL implement states IDLE, WAIT, PRE, BURST, POST with a beat counter sized for BURST_CYCLES and a wait counter sized for WL.
REQ-018 SHALL set ready=1 only in IDLE and POST; write while ready=0 SHALL be ignored.
REQ-019 On acceptance (cycle 0) SHALL go to WAIT if WL>1, else PRE; WAIT lasts WL-1 cycles; PRE occurs in cycle WL.
REQ-020 PRE: dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0, wdata_ack=0.
REQ-021 BURST occupies cycles WL+1..WL+BURST_CYCLES: dq_oe=1, dqs_oe=1, dqs_d0=1, dqs_d1=0.
REQ-022 In BURST with wdata_valid=1: wdata_ack=1, dq_d0=wdata[31:16], dq_d1=wdata[15:0], dm_d0=~wmask[3:2], dm_d1=~wmask[1:0], same cycle (combinational).
REQ-023 In BURST with wdata_valid=0: wdata_ack=0, dq_d0=dq_d1=0, dm_d0=dm_d1=2'b11, underrun set next edge; burst length unchanged (no stall).
REQ-024 POST (one cycle after last beat): dqs_oe=1, dqs 0/0, dq_oe=0; next state IDLE unless write accepted.
REQ-025 Write accepted in POST SHALL restart at WAIT/PRE exactly as from IDLE; dqs_oe stays 1 without gap.
REQ-026 Outside PRE/BURST/POST: dq_oe=dqs_oe=0; all ODDR data/mask/DQS outputs 0; wdata_ack=0.
REQ-027 Control outputs SHALL be Moore decodes of registered state (no dependence on write in the same cycle).
REQ-028 clr_underrun coincident with a new underrun SHALL leave underrun=1 (set wins).
REQ-029 wdata_ack SHALL never assert outside BURST; exactly BURST_CYCLES beats popped per burst when the FIFO never empties.

Reset
REQ-030 sys_rst_n=0 SHALL immediately force state IDLE, counters 0, underrun 0, all outputs 0 except ready=1 once reset deasserts, including mid-burst.
REQ-031 First write SHALL be accepted on the first rising edge with sys_rst_n=1.

Structure
REQ-032 State encodings and WL/BURST_CYCLES defaults SHALL live in the shared hpdmc define/include file used by hpdmc_ddr16.
REQ-033 No sub-module: single FSM plus two counters; module instantiates no ODDR primitives.

Verification
REQ-034 WL=2, BURST_CYCLES=4, FIFO full with 0x11112222,0x33334444,0x55556666,0x77778888, wmask=4'hF: write at cycle 0 -> PRE cycle 2, dq_d0=0x1111/dq_d1=0x2222 cycle 3 ... 0x7777/0x8888 cycle 6, POST cycle 7, IDLE cycle 8, dm all 0.
REQ-035 Same, wdata_valid=0 at cycle 4 only -> cycle 4 dm=2'b11/2'b11, data 0, wdata_ack=0; underrun=1 from cycle 5; bursts still ends cycle 6.
REQ-036 Write in POST (cycle 7) -> second PRE cycle 9, dqs_oe continuously 1 cycles 2..14.
REQ-037 write at cycles 1..6 of a burst -> ignored, ready=0, no extra acks.
REQ-038 sys_rst_n low at cycle 4 -> all outputs 0 same cycle, underrun 0; write after release restarts normally.
REQ-039 wmask=4'b0110 on a beat -> dm_d0=2'b10, dm_d1=2'b01.
